// File: rtl/count_seq_monitor.sv
// Passive monitor for a free-running modulo counter: locks onto a +1 sequence,
// then pulses, counts (saturating) and captures the first sequence error.
module count_seq_monitor #(
  parameter int CW       = 4,
  parameter int LOCK_CNT = 2,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CW-1:0]    count_in,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic             first_err_valid,
  output logic [CW-1:0]    first_err_exp,
  output logic [CW-1:0]    first_err_got
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    LOCKED = 2'd2
  } stateT;

  localparam logic [ERR_W-1:0] ERR_MAX  = '1;
  localparam logic [4:0]       LOCK_TGT = 5'(LOCK_CNT);

  stateT            r_state;
  stateT            w_nextState;
  logic [CW-1:0]    r_prev;
  logic [3:0]       r_run;
  logic [3:0]       w_nextRun;
  logic [4:0]       w_runInc;
  logic [CW-1:0]    w_expected;
  logic             w_match;
  logic             w_error;

  logic             w_nextLocked;
  logic             w_nextPulse;
  logic [ERR_W-1:0] w_errBase;
  logic [ERR_W-1:0] w_nextErrCount;
  logic             w_validBase;
  logic             w_nextValid;
  logic [CW-1:0]    w_nextExp;
  logic [CW-1:0]    w_nextGot;

  assign w_expected = r_prev + CW'(1);
  assign w_match    = (count_in == w_expected);
  assign w_runInc   = {1'b0, r_run} + 5'd1;
  assign w_error    = (r_state == LOCKED) && !w_match;

  // prev tracks the bus every edge, independent of lock state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_prev  <= '0;
      r_run   <= '0;
    end else begin
      r_state <= w_nextState;
      r_prev  <= count_in;
      r_run   <= w_nextRun;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_nextRun   = r_run;
    case (r_state)
      IDLE: begin
        w_nextState = SEARCH;
        w_nextRun   = '0;
      end
      SEARCH: begin
        if (w_match) begin
          if (w_runInc == LOCK_TGT) begin
            w_nextState = LOCKED;
            w_nextRun   = '0;
          end else begin
            w_nextRun = w_runInc[3:0];
          end
        end else begin
          w_nextRun = '0;
        end
      end
      LOCKED: begin
        if (!w_match) begin
          w_nextState = SEARCH;
          w_nextRun   = '0;
        end
      end
      default: begin
        w_nextState = IDLE;
        w_nextRun   = '0;
      end
    endcase
  end

  // Clear is applied first so a coincident error lands on zeroed statistics
  always_comb begin
    w_nextLocked   = (w_nextState == LOCKED);
    w_nextPulse    = w_error;
    w_errBase      = clear ? '0 : err_count;
    w_validBase    = clear ? 1'b0 : first_err_valid;
    w_nextErrCount = w_errBase;
    w_nextValid    = w_validBase;
    w_nextExp      = clear ? '0 : first_err_exp;
    w_nextGot      = clear ? '0 : first_err_got;
    if (w_error) begin
      if (w_errBase != ERR_MAX) begin
        w_nextErrCount = w_errBase + ERR_W'(1);
      end
      if (!w_validBase) begin
        w_nextValid = 1'b1;
        w_nextExp   = w_expected;
        w_nextGot   = count_in;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      locked          <= 1'b0;
      err_pulse       <= 1'b0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_exp   <= '0;
      first_err_got   <= '0;
    end else begin
      locked          <= w_nextLocked;
      err_pulse       <= w_nextPulse;
      err_count       <= w_nextErrCount;
      first_err_valid <= w_nextValid;
      first_err_exp   <= w_nextExp;
      first_err_got   <= w_nextGot;
    end
  end

endmodule
